// File: rtl/uart_rx_oversampled.sv
// ---------------------------------------------------------------------------
// uart_rx_oversampled
// 8N1 UART receiver, LSB first, with its own oversampling tick generator,
// two-flop input synchroniser, saturating-counter noise filter, start-bit
// validation and framing-error detection.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   UART_RXD   in   asynchronous serial line, idles high
//   rx_data    out  [7:0] last correctly framed byte (held until next frame)
//   rx_valid   out  one-cycle pulse when rx_data is updated
//   frame_err  out  one-cycle pulse when a stop bit is sampled low
//   busy       out  high whenever the receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx_oversampled #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 115200,
    parameter int OVERSAMPLING = 8
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       UART_RXD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLING);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLING);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(OVERSAMPLING - 1);
    localparam logic [SC_W-1:0]  SC_MID   = SC_W'(OVERSAMPLING / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic [DIV_W-1:0] div_r;
    logic             tick_s;
    logic [1:0]       sync_r;
    logic             rx_s;
    logic [1:0]       filt_cnt_r;
    logic [1:0]       filt_cnt_n;
    logic             rx_f_r;

    state_t           state_r;
    state_t           state_n;
    logic [SC_W-1:0]  sc_r;
    logic [SC_W-1:0]  sc_n;
    logic [2:0]       bi_r;
    logic [2:0]       bi_n;
    logic [7:0]       shift_r;
    logic [7:0]       shift_n;
    logic [7:0]       rx_data_r;
    logic [7:0]       rx_data_n;
    logic             rx_valid_r;
    logic             rx_valid_n;
    logic             frame_err_r;
    logic             frame_err_n;
    logic             busy_r;

    assign tick_s    = (div_r == DIV_LAST);
    assign rx_s      = sync_r[1];
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

    // Free-running oversampling divider; wraps after the tick cycle.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], UART_RXD};
        end
    end

    // Saturating up/down step of the noise-filter counter.
    always_comb begin
        filt_cnt_n = filt_cnt_r;
        if (rx_s && (filt_cnt_r != 2'd3)) begin
            filt_cnt_n = filt_cnt_r + 2'd1;
        end else if (!rx_s && (filt_cnt_r != 2'd0)) begin
            filt_cnt_n = filt_cnt_r - 2'd1;
        end else begin
            filt_cnt_n = filt_cnt_r;
        end
    end

    // Filter state: the filtered bit follows the counter only at its rails,
    // so a level change needs three consecutive agreeing ticks to pass.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            filt_cnt_r <= 2'd3;
            rx_f_r     <= 1'b1;
        end else if (tick_s) begin
            filt_cnt_r <= filt_cnt_n;
            if (filt_cnt_n == 2'd3) begin
                rx_f_r <= 1'b1;
            end else if (filt_cnt_n == 2'd0) begin
                rx_f_r <= 1'b0;
            end else begin
                rx_f_r <= rx_f_r;
            end
        end else begin
            filt_cnt_r <= filt_cnt_r;
            rx_f_r     <= rx_f_r;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and datapath decisions; everything moves on tick cycles only.
    always_comb begin
        state_n     = state_r;
        sc_n        = sc_r;
        bi_n        = bi_r;
        shift_n     = shift_r;
        rx_data_n   = rx_data_r;
        rx_valid_n  = 1'b0;
        frame_err_n = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_f_r) begin
                        state_n = ST_START;
                        sc_n    = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_START: begin
                    // Re-check the line half a bit in to reject short lows.
                    if (sc_r == SC_MID) begin
                        if (!rx_f_r) begin
                            state_n = ST_DATA;
                            sc_n    = '0;
                            bi_n    = 3'd0;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        sc_n = sc_r + SC_W'(1);
                    end
                end
                ST_DATA: begin
                    if (sc_r == SC_LAST) begin
                        shift_n = {rx_f_r, shift_r[7:1]};
                        sc_n    = '0;
                        if (bi_r == 3'd7) begin
                            state_n = ST_STOP;
                        end else begin
                            bi_n = bi_r + 3'd1;
                        end
                    end else begin
                        sc_n = sc_r + SC_W'(1);
                    end
                end
                ST_STOP: begin
                    // Decided mid stop bit so the next start edge is not missed.
                    if (sc_r == SC_LAST) begin
                        sc_n = '0;
                        if (rx_f_r) begin
                            rx_data_n  = shift_r;
                            rx_valid_n = 1'b1;
                            state_n    = ST_IDLE;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = ST_BREAK;
                        end
                    end else begin
                        sc_n = sc_r + SC_W'(1);
                    end
                end
                ST_BREAK: begin
                    // A held-low line must go high before a new start is armed.
                    if (rx_f_r) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_BREAK;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Datapath and registered outputs; busy tracks the state register exactly.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sc_r        <= '0;
            bi_r        <= 3'd0;
            shift_r     <= 8'h00;
            rx_data_r   <= 8'h00;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            sc_r        <= sc_n;
            bi_r        <= bi_n;
            shift_r     <= shift_n;
            rx_data_r   <= rx_data_n;
            rx_valid_r  <= rx_valid_n;
            frame_err_r <= frame_err_n;
            busy_r      <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_oversampled
// Directed bench for uart_rx_oversampled at default parameters, 434 clocks
// per bit on the line. Expected bytes go into a scoreboard queue as frames
// are driven; a monitor pops and compares on every rx_valid pulse.
// ---------------------------------------------------------------------------
module tb_uart_rx_oversampled;

    localparam int BIT_CLKS = 434;

    logic       CLOCK_50 = 1'b0;
    logic       rst      = 1'b1;
    logic       UART_RXD = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         valid_cnt = 0;
    int         ferr_cnt  = 0;
    int         busy_cyc  = 0;
    longint     cyc       = 0;
    longint     start_cyc = 0;
    longint     valid_cyc = 0;
    logic       mon_en     = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;

    uart_rx_oversampled dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .UART_RXD  (UART_RXD),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold one bit value on the line for a full bit time (called on a negedge).
    task automatic drive_bit(input logic b);
        UART_RXD = b;
        repeat (BIT_CLKS) @(negedge CLOCK_50);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input logic push);
        if (push) exp_q.push_back(d);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    // Monitor: scoreboard pop on rx_valid plus pulse-shape checks.
    always @(negedge CLOCK_50) begin
        cyc++;
        if (mon_en) begin
            if (rx_valid) begin
                valid_cnt++;
                valid_cyc = cyc;
                if (exp_q.size() == 0) check("unexpected_valid", rx_valid, 0);
                else check("rx_data", rx_data, exp_q.pop_front());
            end
            if (frame_err) ferr_cnt++;
            if (rx_valid || frame_err) check("valid_ferr_exclusive", rx_valid & frame_err, 0);
            if (prev_valid) check("valid_one_cycle", rx_valid, 0);
            if (prev_ferr) check("ferr_one_cycle", frame_err, 0);
            if (busy) busy_cyc++;
            prev_valid = rx_valid;
            prev_ferr  = frame_err;
        end
    end

    initial begin
        int vb;
        int fb;
        longint lat;

        // 1. Reset
        rst = 1'b1;
        UART_RXD = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        rst = 1'b0;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_busy", busy, 0);
        mon_en = 1'b1;
        repeat (2000) @(negedge CLOCK_50);
        check("idle_valid_cnt", valid_cnt, 0);
        check("idle_ferr_cnt", ferr_cnt, 0);
        check("idle_busy_cyc", busy_cyc, 0);
        check("idle_rx_data", rx_data, 8'h00);

        // 2. Single byte
        send_byte(8'hA5, 1'b1, 1'b1);
        check("single_busy_before_stop_end", busy, 0);
        check("single_valid_cnt", valid_cnt, 1);
        check("single_ferr_cnt", ferr_cnt, 0);
        lat = valid_cyc - start_cyc;
        check("single_latency_window",
              ((lat >= 64'(BIT_CLKS * 19 / 2)) && (lat <= 64'(BIT_CLKS * 10))) ? 1 : 0, 1);
        repeat (200) @(negedge CLOCK_50);

        // 3. Back-to-back
        vb = valid_cnt;
        send_byte(8'h00, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        send_byte(8'h55, 1'b1, 1'b1);
        repeat (BIT_CLKS) @(negedge CLOCK_50);
        check("b2b_valid_cnt", valid_cnt - vb, 3);
        check("b2b_rx_data_last", rx_data, 8'h55);
        check("b2b_ferr_cnt", ferr_cnt, 0);

        // 4. Glitch rejection
        vb = valid_cnt;
        fb = ferr_cnt;
        busy_cyc = 0;
        UART_RXD = 1'b0;
        repeat (100) @(negedge CLOCK_50);
        UART_RXD = 1'b1;
        repeat (1000) @(negedge CLOCK_50);
        check("glitch_busy_cyc", busy_cyc, 0);
        check("glitch_valid", valid_cnt - vb, 0);
        check("glitch_ferr", ferr_cnt - fb, 0);

        // 5. Framing error and break
        vb = valid_cnt;
        fb = ferr_cnt;
        send_byte(8'h3C, 1'b0, 1'b0);
        UART_RXD = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge CLOCK_50);
        check("break_busy_held", busy, 1);
        check("break_ferr_cnt", ferr_cnt - fb, 1);
        check("break_valid_cnt", valid_cnt - vb, 0);
        check("break_rx_data_kept", rx_data, 8'h55);
        UART_RXD = 1'b1;
        repeat (BIT_CLKS) @(negedge CLOCK_50);
        check("break_busy_released", busy, 0);
        send_byte(8'h81, 1'b1, 1'b1);
        repeat (BIT_CLKS) @(negedge CLOCK_50);
        check("after_break_valid_cnt", valid_cnt - vb, 1);
        check("after_break_ferr_cnt", ferr_cnt - fb, 1);
        check("after_break_rx_data", rx_data, 8'h81);

        // 6. Reset mid-frame during data bit 4 of 0x5A
        vb = valid_cnt;
        fb = ferr_cnt;
        begin
            logic [7:0] d;
            d = 8'h5A;
            drive_bit(1'b0);
            for (int i = 0; i < 4; i++) drive_bit(d[i]);
            UART_RXD = d[4];
            repeat (BIT_CLKS / 2) @(negedge CLOCK_50);
        end
        check("midframe_busy_before_rst", busy, 1);
        rst = 1'b1;
        UART_RXD = 1'b1;
        @(negedge CLOCK_50);
        rst = 1'b0;
        check("midframe_busy_after_rst", busy, 0);
        check("midframe_rx_data_after_rst", rx_data, 8'h00);
        repeat (2000) @(negedge CLOCK_50);
        check("midframe_valid_cnt", valid_cnt - vb, 0);
        check("midframe_ferr_cnt", ferr_cnt - fb, 0);
        send_byte(8'hC3, 1'b1, 1'b1);
        repeat (BIT_CLKS) @(negedge CLOCK_50);
        check("after_rst_valid_cnt", valid_cnt - vb, 1);
        check("after_rst_rx_data", rx_data, 8'hC3);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
